vx_csr_req_arb: RTL

VX_CSR_REQ_ARB -- requirements
Module: VX_csr_req_arb

---
 rtl/vx_csr_req_arb_pkg.sv | 50 +++++
 rtl/vx_csr_req_arb_rr.sv | 54 +++++
 rtl/vx_csr_req_arb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vx_csr_req_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vx_csr_req_arb_pkg : shared CSR widths, op encoding and op helpers   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vx_csr_req_arb_pkg;

  localparam int XLEN          = 32;
  localparam int NW_WIDTH      = 2;
  localparam int UUID_WIDTH    = 8;
  localparam int CSR_ADDR_BITS = 12;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_t;

  function automatic logic [XLEN-1:0] csr_new_value(
    input csr_op_t         op,
    input logic [XLEN-1:0] old,
    input logic [XLEN-1:0] data
  );
    logic [XLEN-1:0] val;
    val = old;
    case (op)
      CSR_WRITE: val = data;
      CSR_SET:   val = old | data;
      CSR_CLEAR: val = old & ~data;
      default:   val = old;
    endcase
    return val;
  endfunction

  // SET/CLEAR with a zero mask are pure reads; addr[11:10]==3 is read-only space.
  function automatic logic csr_writes(
    input csr_op_t                  op,
    input logic [CSR_ADDR_BITS-1:0] addr,
    input logic [XLEN-1:0]          data
  );
    logic wr;
    wr = (op != CSR_READ);
    if ((op == CSR_SET || op == CSR_CLEAR) && data == '0) wr = 1'b0;
    if (addr[11:10] == 2'b11) wr = 1'b0;
    return wr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_csr_req_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vx_csr_req_arb_rr : round-robin requester select, advances on unlock |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vx_csr_req_arb_rr #(
  parameter int NUM_REQS = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                unlock,
  output logic                grant_valid,
  output logic [SEL_BITS-1:0] grant_idx
);

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS:0]   cand;
  logic [SEL_BITS:0]   nxt;
  logic                found;

  assign grant_valid = |requests;

  // Scan from the priority pointer, wrapping once past the last requester.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = {1'b0, ptr} + (SEL_BITS+1)'(i);
      if (cand >= (SEL_BITS+1)'(NUM_REQS)) cand = cand - (SEL_BITS+1)'(NUM_REQS);
      if (!found && requests[cand[SEL_BITS-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SEL_BITS-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, grant_idx} + (SEL_BITS+1)'(1);
    if (nxt >= (SEL_BITS+1)'(NUM_REQS)) nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (unlock) begin
      ptr <= nxt[SEL_BITS-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_csr_req_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vx_csr_req_arb : serialises CSR requesters onto one CSR data block   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vx_csr_req_arb
  import vx_csr_req_arb_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQS-1:0]                    req_valid,
  output logic [NUM_REQS-1:0]                    req_ready,
  input  logic [NUM_REQS-1:0][1:0]               req_op,
  input  logic [NUM_REQS-1:0][NW_WIDTH-1:0]      req_wid,
  input  logic [NUM_REQS-1:0][UUID_WIDTH-1:0]    req_uuid,
  input  logic [NUM_REQS-1:0][CSR_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQS-1:0][XLEN-1:0]          req_data,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [REQ_SEL_BITS-1:0]                rsp_idx,
  output logic [XLEN-1:0]                        rsp_data,
  output logic [UUID_WIDTH-1:0]                  rsp_uuid,
  output logic                                   read_enable,
  output logic [UUID_WIDTH-1:0]                  read_uuid,
  output logic [NW_WIDTH-1:0]                    read_wid,
  output logic [CSR_ADDR_BITS-1:0]               read_addr,
  input  logic [XLEN-1:0]                        read_data_ro,
  input  logic [XLEN-1:0]                        read_data_rw,
  output logic                                   write_enable,
  output logic [UUID_WIDTH-1:0]                  write_uuid,
  output logic [NW_WIDTH-1:0]                    write_wid,
  output logic [CSR_ADDR_BITS-1:0]               write_addr,
  output logic [XLEN-1:0]                        write_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  state_t                    state;
  csr_op_t                   op_q;
  logic [NW_WIDTH-1:0]       wid_q;
  logic [UUID_WIDTH-1:0]     uuid_q;
  logic [CSR_ADDR_BITS-1:0]  addr_q;
  logic [XLEN-1:0]           data_q;
  logic [REQ_SEL_BITS-1:0]   idx_q;
  logic [XLEN-1:0]           old_q;
  logic [XLEN-1:0]           wdata_q;
  logic                      re_q;
  logic                      we_q;
  logic                      rv_q;

  logic                      grant_valid;
  logic [REQ_SEL_BITS-1:0]   grant_idx;
  logic                      grant_fire;
  logic [XLEN-1:0]           rd_val;

  assign grant_fire = reset && (state == S_IDLE) && grant_valid;
  assign rd_val     = read_data_ro | read_data_rw;

  vx_csr_req_arb_rr #(
    .NUM_REQS (NUM_REQS),
    .SEL_BITS (REQ_SEL_BITS)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .requests    (req_valid),
    .unlock      (grant_fire),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= CSR_READ;
      wid_q   <= '0;
      uuid_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      old_q   <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            op_q   <= csr_op_t'(req_op[grant_idx]);
            wid_q  <= req_wid[grant_idx];
            uuid_q <= req_uuid[grant_idx];
            addr_q <= req_addr[grant_idx];
            data_q <= req_data[grant_idx];
            idx_q  <= grant_idx;
            re_q   <= 1'b1;
            state  <= S_RD;
          end
        end
        S_RD: begin
          re_q    <= 1'b0;
          old_q   <= rd_val;
          wdata_q <= csr_new_value(op_q, rd_val, data_q);
          we_q    <= csr_writes(op_q, addr_q, data_q);
          state   <= S_WR;
        end
        S_WR: begin
          we_q  <= 1'b0;
          rv_q  <= 1'b1;
          state <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rv_q  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an access caught mid-flight is dropped at once.
  assign req_ready    = grant_fire ? (NUM_REQS'(1) << grant_idx) : '0;
  assign read_enable  = re_q & reset;
  assign write_enable = we_q & reset;
  assign rsp_valid    = rv_q & reset;

  assign read_uuid  = uuid_q;
  assign read_wid   = wid_q;
  assign read_addr  = addr_q;
  assign write_uuid = uuid_q;
  assign write_wid  = wid_q;
  assign write_addr = addr_q;
  assign write_data = wdata_q;
  assign rsp_idx    = idx_q;
  assign rsp_data   = old_q;
  assign rsp_uuid   = uuid_q;

endmodule
`default_nettype wire
